// File: rtl/sp_instr_decoder.sv
// sp_instr_decoder: expands instruction FIFO words into per-row DRAM or scratchpad read requests.
// Ports: CLK/nRST; instr_valid/instr_ready/instr_data in; rreq_valid/rreq_ready/rreq_data
// (scratchpad reads {addr, mat_t, mat_s, row_s}); dreq_valid/dreq_ready/dreq_addr/dreq_mat_s/dreq_row_s
// (DRAM reads); gemm_issue/gemm_dest; busy. Macro SP_DECODE_ERR_EN adds decode_err_cnt.
module sp_instr_decoder #(
  parameter int WORD_W  = 32,
  parameter int MAT_S_W = 4,
  parameter int ROW_S_W = 2,
  parameter int STRIDE  = 8
) (
  input  logic                                 CLK,
  input  logic                                 nRST,
  input  logic                                 instr_valid,
  output logic                                 instr_ready,
  input  logic [WORD_W+7:0]                    instr_data,
  output logic                                 rreq_valid,
  input  logic                                 rreq_ready,
  output logic [WORD_W+MAT_S_W+ROW_S_W+1:0]    rreq_data,
  output logic                                 dreq_valid,
  input  logic                                 dreq_ready,
  output logic [WORD_W-1:0]                    dreq_addr,
  output logic [MAT_S_W-1:0]                   dreq_mat_s,
  output logic [ROW_S_W-1:0]                   dreq_row_s,
  output logic                                 gemm_issue,
  output logic [MAT_S_W-1:0]                   gemm_dest,
  output logic                                 busy
`ifdef SP_DECODE_ERR_EN
  ,
  output logic [7:0]                           decode_err_cnt
`endif
);
  typedef enum logic [2:0] {S_IDLE, S_LD, S_ST, S_GA, S_GB, S_GC} state_t;
  state_t state;
  logic [1:0] op;
  logic [5:0] field;
  logic [WORD_W-1:0] word;
  logic [ROW_S_W-1:0] row, row_n;
  logic [MAT_S_W-1:0] mb, mc, md;
  logic nw, last, to_b;
  logic [WORD_W-1:0] r_addr;
  logic [MAT_S_W+1:0] r_sel;
  assign {op, field, word} = instr_data;
  assign instr_ready = state == S_IDLE;
  assign busy = state != S_IDLE;
  assign row_n = row + ROW_S_W'(1);
  assign last = &row;
  assign to_b = state == S_GA && nw;
  // mat_t/mat_s and address fields of the currently presented scratchpad request
  assign r_addr = rreq_data[WORD_W+MAT_S_W+ROW_S_W+1 -: WORD_W];
  assign r_sel = rreq_data[MAT_S_W+ROW_S_W+1 : ROW_S_W];
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= S_IDLE;
      row <= '0;
      nw <= 1'b0;
      mb <= '0;
      mc <= '0;
      md <= '0;
      rreq_valid <= 1'b0;
      rreq_data <= '0;
      dreq_valid <= 1'b0;
      dreq_addr <= '0;
      dreq_mat_s <= '0;
      dreq_row_s <= '0;
      gemm_issue <= 1'b0;
      gemm_dest <= '0;
    end else begin
      gemm_issue <= 1'b0;
      gemm_dest <= '0;
      case (state)
        S_IDLE: if (instr_valid) begin
          row <= '0;
          nw <= field[3];
          mb <= word[2*MAT_S_W +: MAT_S_W];
          mc <= word[MAT_S_W +: MAT_S_W];
          md <= word[0 +: MAT_S_W];
          case (op)
            2'b01: begin
              state <= S_LD;
              dreq_valid <= 1'b1;
              dreq_addr <= word;
              dreq_mat_s <= field[MAT_S_W-1:0];
              dreq_row_s <= '0;
            end
            2'b10: begin
              state <= S_ST;
              rreq_valid <= 1'b1;
              rreq_data <= {word, 2'b00, field[MAT_S_W-1:0], {ROW_S_W{1'b0}}};
            end
            2'b11: begin
              state <= S_GA;
              rreq_valid <= 1'b1;
              rreq_data <= {{WORD_W{1'b0}}, 2'b01, word[3*MAT_S_W +: MAT_S_W], {ROW_S_W{1'b0}}};
            end
            default: ;
          endcase
        end
        S_LD: if (dreq_ready) begin
          row <= last ? '0 : row_n;
          if (last) begin
            state <= S_IDLE;
            dreq_valid <= 1'b0;
          end else begin
            dreq_addr <= dreq_addr + WORD_W'(STRIDE);
            dreq_row_s <= row_n;
          end
        end
        S_ST, S_GA, S_GB, S_GC: if (rreq_ready) begin
          row <= last ? '0 : row_n;
          // GEMM operand rows always read from address 0; only stores stride
          if (!last)
            rreq_data <= {r_addr + (state == S_ST ? WORD_W'(STRIDE) : {WORD_W{1'b0}}), r_sel, row_n};
          else if (state == S_ST) begin
            state <= S_IDLE;
            rreq_valid <= 1'b0;
          end else if (state == S_GC) begin
            state <= S_IDLE;
            rreq_valid <= 1'b0;
            gemm_issue <= 1'b1;
            gemm_dest <= md;
          end else begin
            state <= to_b ? S_GB : S_GC;
            rreq_data <= {{WORD_W{1'b0}}, to_b ? 2'b10 : 2'b11, to_b ? mb : mc, {ROW_S_W{1'b0}}};
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
`ifdef SP_DECODE_ERR_EN
  // malformed NOPs and LOAD/STORE with reserved field bits set are counted, saturating at 255
  logic bad;
  assign bad = (op == 2'b00 && (|field || |word)) || ((op == 2'b01 || op == 2'b10) && |field[5:4]);
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) decode_err_cnt <= '0;
    else if (instr_valid && instr_ready && bad && decode_err_cnt != 8'hFF) decode_err_cnt <= decode_err_cnt + 8'd1;
  end
`else
  logic unused_field;
  assign unused_field = ^field[5:4];
`endif
endmodule

// File: tb/tb_sp_instr_decoder.sv
// tb_sp_instr_decoder: directed self-checking bench for sp_instr_decoder.
module tb_sp_instr_decoder;
  logic CLK = 1'b0;
  logic nRST = 1'b0;
  logic instr_valid = 1'b0;
  logic instr_ready;
  logic [39:0] instr_data = '0;
  logic rreq_valid;
  logic rreq_ready = 1'b0;
  logic [39:0] rreq_data;
  logic dreq_valid;
  logic dreq_ready = 1'b0;
  logic [31:0] dreq_addr;
  logic [3:0] dreq_mat_s;
  logic [1:0] dreq_row_s;
  logic gemm_issue;
  logic [3:0] gemm_dest;
  logic busy;
`ifdef SP_DECODE_ERR_EN
  logic [7:0] decode_err_cnt;
`endif
  int checks = 0;
  int failures = 0;

  sp_instr_decoder dut (
    .CLK(CLK), .nRST(nRST),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_data(instr_data),
    .rreq_valid(rreq_valid), .rreq_ready(rreq_ready), .rreq_data(rreq_data),
    .dreq_valid(dreq_valid), .dreq_ready(dreq_ready), .dreq_addr(dreq_addr),
    .dreq_mat_s(dreq_mat_s), .dreq_row_s(dreq_row_s),
    .gemm_issue(gemm_issue), .gemm_dest(gemm_dest), .busy(busy)
`ifdef SP_DECODE_ERR_EN
    , .decode_err_cnt(decode_err_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [39:0] d);
    @(negedge CLK);
    chk("instr_ready_idle", 64'(instr_ready), 64'd1);
    instr_valid = 1'b1;
    instr_data = d;
    @(negedge CLK);
    instr_valid = 1'b0;
    instr_data = '0;
  endtask

  task automatic gemm_run(input logic nw, input logic [31:0] w);
    int n;
    logic [1:0] mt;
    logic [3:0] ms;
    n = nw ? 3 : 2;
    rreq_ready = 1'b1;
    issue({2'b11, 2'b00, nw, 3'b000, w});
    for (int k = 0; k < n; k++) begin
      mt = (k == 0) ? 2'b01 : (k == n - 1) ? 2'b11 : 2'b10;
      ms = (k == 0) ? w[15:12] : (k == n - 1) ? w[7:4] : w[11:8];
      for (int i = 0; i < 4; i++) begin
        chk("gemm_rvalid", 64'(rreq_valid), 64'd1);
        chk("gemm_rdata", 64'(rreq_data), 64'({32'h0, mt, ms, 2'(i)}));
        chk("gemm_no_issue", 64'(gemm_issue), 64'd0);
        @(negedge CLK);
      end
    end
    chk("gemm_issue", 64'(gemm_issue), 64'd1);
    chk("gemm_dest", 64'(gemm_dest), 64'(w[3:0]));
    chk("gemm_rvalid_off", 64'(rreq_valid), 64'd0);
    @(negedge CLK);
    chk("gemm_issue_pulse", 64'(gemm_issue), 64'd0);
    chk("gemm_dest_zero", 64'(gemm_dest), 64'd0);
  endtask

  initial begin
    int r;
    logic rdy;
    repeat (2) @(negedge CLK);
    chk("rst_rvalid", 64'(rreq_valid), 64'd0);
    chk("rst_dvalid", 64'(dreq_valid), 64'd0);
    chk("rst_gemm", 64'(gemm_issue), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_rdata", 64'(rreq_data), 64'd0);
    chk("rst_daddr", 64'(dreq_addr), 64'd0);
    nRST = 1'b1;

    // LOAD mat=5 base=0x1000
    dreq_ready = 1'b1;
    issue({2'b01, 6'd5, 32'h1000});
    for (int i = 0; i < 4; i++) begin
      chk("ld_dvalid", 64'(dreq_valid), 64'd1);
      chk("ld_rvalid", 64'(rreq_valid), 64'd0);
      chk("ld_addr", 64'(dreq_addr), 64'(32'h1000 + 32'(i * 8)));
      chk("ld_mat", 64'(dreq_mat_s), 64'd5);
      chk("ld_row", 64'(dreq_row_s), 64'(i));
      chk("ld_busy", 64'(busy), 64'd1);
      @(negedge CLK);
    end
    chk("ld_done_valid", 64'(dreq_valid), 64'd0);
    chk("ld_done_busy", 64'(busy), 64'd0);
    chk("ld_done_ready", 64'(instr_ready), 64'd1);
    dreq_ready = 1'b0;

    // STORE mat=3 base=0x20 with toggling ready
    issue({2'b10, 6'd3, 32'h20});
    r = 0;
    rdy = 1'b1;
    for (int c = 0; c < 16 && r < 4; c++) begin
      chk("st_rvalid", 64'(rreq_valid), 64'd1);
      chk("st_dvalid", 64'(dreq_valid), 64'd0);
      chk("st_rdata", 64'(rreq_data), 64'({32'h20 + 32'(r * 8), 2'b00, 4'd3, 2'(r)}));
      rreq_ready = rdy;
      @(negedge CLK);
      if (rdy) r++;
      rdy = !rdy;
    end
    chk("st_rows", 64'(r), 64'd4);
    chk("st_done_valid", 64'(rreq_valid), 64'd0);
    chk("st_done_busy", 64'(busy), 64'd0);

    gemm_run(1'b1, 32'h1234);
    gemm_run(1'b0, 32'hABCD);

    // STORE with address wrap, reset mid-instruction
    rreq_ready = 1'b1;
    issue({2'b10, 6'd7, 32'hFFFF_FFF8});
    chk("wrap_r0", 64'(rreq_data), 64'({32'hFFFF_FFF8, 2'b00, 4'd7, 2'd0}));
    @(negedge CLK);
    chk("wrap_r1", 64'(rreq_data), 64'({32'h0, 2'b00, 4'd7, 2'd1}));
    @(posedge CLK);
    #1 nRST = 1'b0;
    #1;
    chk("arst_rvalid", 64'(rreq_valid), 64'd0);
    chk("arst_dvalid", 64'(dreq_valid), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    @(negedge CLK);
    nRST = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("post_rst_rvalid", 64'(rreq_valid), 64'd0);
      chk("post_rst_idle", 64'(instr_ready), 64'd1);
    end

    // NOP with nonzero word
    issue({2'b00, 6'd0, 32'h1});
    chk("nop_busy", 64'(busy), 64'd0);
    chk("nop_rvalid", 64'(rreq_valid), 64'd0);
    chk("nop_dvalid", 64'(dreq_valid), 64'd0);
    chk("nop_ready", 64'(instr_ready), 64'd1);
`ifdef SP_DECODE_ERR_EN
    chk("nop_errcnt", 64'(decode_err_cnt), 64'd1);
`endif
    @(negedge CLK);
    chk("nop_stay_idle", 64'(rreq_valid | dreq_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
